// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates instruction fetch and LDR/STR onto one memory port
// and runs each access as a req/ack transaction with a timeout.
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_DATA_RUN   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic [7:0]  pc,
    output logic        fetch_done,
    output logic [31:0] instr,
    input  logic        data_req,
    input  logic [3:0]  op_code,
    input  logic [31:0] SR1,
    input  logic [31:0] SR2,
    output logic        data_done,
    output logic [31:0] data_reg,
    output logic        mem_req,
    output logic        RW,
    output logic [31:0] add_bus,
    output logic [31:0] data_bus,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err
);
    localparam logic [3:0] LDR = 4'b1101;
    localparam logic [3:0] STR = 4'b1110;
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

    state_t state, state_nx;
    logic [RUN_W-1:0] data_run;
    logic [CNT_W-1:0] wait_cnt;
    logic is_fetch, is_ldr, err, settle;
    logic arb_ok, fetch_ok, data_ok, pick_data, pick_fetch, legal, ack, expire;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (pick_data ? (legal ? DATA : DONE) : pick_fetch ? FETCH : IDLE) :
                   state == DONE ? IDLE :
                   (ack || expire) ? DONE : state;

    // Arbitration pauses for the done cycle and the one after, so requesters can drop their level.
    always_comb begin
        arb_ok     = state == IDLE && !(fetch_done || data_done || settle);
        fetch_ok   = arb_ok && fetch_req;
        data_ok    = arb_ok && data_req;
        pick_data  = data_ok && !(fetch_ok && data_run == RUN_W'(MAX_DATA_RUN));
        pick_fetch = fetch_ok && !pick_data;
        legal      = op_code == LDR || op_code == STR;
        ack        = mem_req && mem_ack;
        expire     = mem_req && !mem_ack && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_req    <= 1'b0;
            RW         <= 1'b0;
            add_bus    <= '0;
            data_bus   <= '0;
            instr      <= '0;
            data_reg   <= '0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            mem_err    <= 1'b0;
            data_run   <= '0;
            wait_cnt   <= '0;
            is_fetch   <= 1'b0;
            is_ldr     <= 1'b0;
            err        <= 1'b0;
            settle     <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            mem_err    <= 1'b0;
            settle     <= fetch_done || data_done;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    err      <= 1'b0;
                    if (pick_fetch) begin
                        data_run <= '0;
                        is_fetch <= 1'b1;
                        add_bus  <= {24'b0, pc};
                        RW       <= 1'b1;
                        data_bus <= '0;
                    end
                    if (pick_data) begin
                        data_run <= fetch_ok ? data_run + RUN_W'(1) : data_run;
                        is_fetch <= 1'b0;
                        is_ldr   <= op_code == LDR;
                        err      <= !legal;
                        if (legal) begin
                            add_bus  <= SR1;
                            RW       <= op_code == LDR;
                            data_bus <= op_code == STR ? SR2 : 32'b0;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (!mem_req) mem_req <= 1'b1;
                    else if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (is_fetch) instr <= mem_rdata;
                        else if (is_ldr) data_reg <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (expire) begin
                            mem_req <= 1'b0;
                            err     <= 1'b1;
                        end
                    end
                end
                default: begin
                    fetch_done <= is_fetch;
                    data_done  <= !is_fetch;
                    mem_err    <= err;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed scenarios for the shared memory port sequencer.
module tb_mem_access_sequencer;
    logic        Clk = 0, Reset = 1;
    logic        fetch_req = 0, data_req = 0, mem_ack = 0;
    logic [7:0]  pc = '0;
    logic [3:0]  op_code = '0;
    logic [31:0] SR1 = '0, SR2 = '0, mem_rdata = '0;
    logic        fetch_done, data_done, mem_req, RW, mem_err;
    logic [31:0] instr, data_reg, add_bus, data_bus;

    int checks = 0, errors = 0;
    int rc, lat, fd, dd, er, ewd;
    bit st;
    logic [31:0] a0, d0, exp_data;
    logic r0;

    mem_access_sequencer #(.TIMEOUT_CYCLES(16), .MAX_DATA_RUN(4)) dut (
        .Clk(Clk), .Reset(Reset), .fetch_req(fetch_req), .pc(pc), .fetch_done(fetch_done),
        .instr(instr), .data_req(data_req), .op_code(op_code), .SR1(SR1), .SR2(SR2),
        .data_done(data_done), .data_reg(data_reg), .mem_req(mem_req), .RW(RW),
        .add_bus(add_bus), .data_bus(data_bus), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err)
    );

    always #5 Clk = ~Clk;

    // Plays memory and requester for one transaction; ack_after<0 means never acknowledge.
    task automatic xact(input int ack_after, input logic [31:0] rdata);
        rc = 0; lat = -1; fd = 0; dd = 0; er = 0; ewd = 0; st = 1;
        a0 = '0; d0 = '0; r0 = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge Clk);
            if (mem_req) begin
                if (rc == 0) begin a0 = add_bus; r0 = RW; d0 = data_bus; end
                else if ({add_bus, RW, data_bus} !== {a0, r0, d0}) st = 0;
                rc++;
            end
            mem_ack = ack_after >= 0 && mem_req && rc == ack_after + 1;
            mem_rdata = mem_ack ? rdata : 32'hBAD0BAD0;
            if (fetch_done) fd++;
            if (data_done) dd++;
            if (mem_err) er++;
            if (mem_err && (fetch_done || data_done)) ewd++;
            if (lat >= 0 && i == lat + 1) begin fetch_req = 0; data_req = 0; end
            if ((fetch_done || data_done) && lat < 0) lat = i;
            if (lat >= 0 && i == lat + 4) break;
        end
        mem_ack = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        checks++; if ({mem_req, RW, fetch_done, data_done, mem_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {mem_req, RW, fetch_done, data_done, mem_err}); end
        checks++; if ({add_bus, data_bus} !== 64'b0) begin errors++; $display("FAIL reset_buses got %h want 0", {add_bus, data_bus}); end
        checks++; if ({instr, data_reg} !== 64'b0) begin errors++; $display("FAIL reset_regs got %h want 0", {instr, data_reg}); end
        Reset = 0;
        repeat (3) @(negedge Clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b want 0", mem_req); end
    endtask

    task automatic test_fetch;
        pc = 8'h3C; fetch_req = 1;
        xact(2, 32'hDEADBEEF);
        checks++; if (a0 !== 32'h3C || r0 !== 1'b1 || d0 !== 32'h0) begin errors++; $display("FAIL fetch_bus got %h/%b/%h want 3c/1/0", a0, r0, d0); end
        checks++; if (rc !== 3 || st !== 1'b1) begin errors++; $display("FAIL fetch_req_cycles got %0d stable %0d want 3 stable 1", rc, st); end
        checks++; if (instr !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_instr got %h want deadbeef", instr); end
        checks++; if (fd !== 1 || dd !== 0 || er !== 0) begin errors++; $display("FAIL fetch_pulses got fd%0d dd%0d er%0d want 1 0 0", fd, dd, er); end
    endtask

    task automatic test_ldr;
        op_code = 4'b1101; SR1 = 32'h80; SR2 = 32'h9999; data_req = 1;
        xact(0, 32'h12345678);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ldr_latency got %0d want 4", lat); end
        checks++; if (a0 !== 32'h80 || r0 !== 1'b1 || d0 !== 32'h0) begin errors++; $display("FAIL ldr_bus got %h/%b/%h want 80/1/0", a0, r0, d0); end
        checks++; if (data_reg !== 32'h12345678 || instr !== 32'hDEADBEEF) begin errors++; $display("FAIL ldr_regs got %h/%h want 12345678/deadbeef", data_reg, instr); end
        checks++; if (dd !== 1 || fd !== 0 || rc !== 1) begin errors++; $display("FAIL ldr_pulses got dd%0d fd%0d rc%0d want 1 0 1", dd, fd, rc); end
    endtask

    task automatic test_store;
        op_code = 4'b1110; SR1 = 32'h100; SR2 = 32'h55AA; data_req = 1;
        xact(3, 32'h77777777);
        checks++; if (a0 !== 32'h100 || r0 !== 1'b0 || d0 !== 32'h55AA) begin errors++; $display("FAIL str_bus got %h/%b/%h want 100/0/55aa", a0, r0, d0); end
        checks++; if (st !== 1'b1 || rc !== 4) begin errors++; $display("FAIL str_hold got stable %0d rc %0d want 1 4", st, rc); end
        checks++; if (data_reg !== 32'h12345678) begin errors++; $display("FAIL str_data_reg got %h want 12345678", data_reg); end
        checks++; if (dd !== 1 || er !== 0) begin errors++; $display("FAIL str_pulses got dd%0d er%0d want 1 0", dd, er); end
    endtask

    task automatic test_data_run;
        logic [6:0] order;
        int ng, nd, nf, tail;
        bit prev, ddrop, dre, fdrop, both;
        order = '0; ng = 0; nd = 0; nf = 0; tail = 0; prev = 0; ddrop = 0; dre = 0; fdrop = 0; both = 0;
        pc = 8'h40; op_code = 4'b1101; SR1 = 32'h200; fetch_req = 1; data_req = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (fetch_done && data_done) both = 1;
            if (mem_req && !prev) begin
                if (ng < 7) order[ng] = add_bus == 32'h40;
                ng++;
            end
            prev = mem_req;
            mem_ack = mem_req;
            mem_rdata = 32'h11110000 + 32'(ng);
            if (mem_req && add_bus != 32'h40) exp_data = mem_rdata;
            if (ddrop) begin data_req = 0; ddrop = 0; dre = nd < 6; end
            else if (dre) begin data_req = 1; dre = 0; end
            if (fdrop) begin fetch_req = 0; fdrop = 0; end
            if (data_done) begin nd++; ddrop = 1; end
            if (fetch_done) begin nf++; fdrop = 1; end
            if (nd == 6) tail++;
            if (tail == 4) break;
        end
        mem_ack = 0;
        checks++; if (ng !== 7 || nd !== 6 || nf !== 1) begin errors++; $display("FAIL run_counts got grants %0d data %0d fetch %0d want 7 6 1", ng, nd, nf); end
        checks++; if (order !== 7'b0010000) begin errors++; $display("FAIL run_order got %b want 0010000 (bit i=1 fetch)", order); end
        checks++; if (data_reg !== exp_data) begin errors++; $display("FAIL run_data_reg got %h want %h", data_reg, exp_data); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL run_done_overlap got %b want 0", both); end
    endtask

    task automatic test_timeout;
        op_code = 4'b1101; SR1 = 32'h300; data_req = 1;
        xact(-1, 32'h0);
        checks++; if (rc !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d want 16", rc); end
        checks++; if (dd !== 1 || ewd !== 1 || er !== 1 || fd !== 0) begin errors++; $display("FAIL timeout_pulses got dd%0d ewd%0d er%0d fd%0d want 1 1 1 0", dd, ewd, er, fd); end
        checks++; if (data_reg !== exp_data) begin errors++; $display("FAIL timeout_data_reg got %h want %h", data_reg, exp_data); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req_low got %b want 0", mem_req); end
    endtask

    task automatic test_illegal;
        op_code = 4'b0011; SR1 = 32'h500; data_req = 1;
        xact(0, 32'h5A5A5A5A);
        checks++; if (rc !== 0) begin errors++; $display("FAIL illegal_no_req got %0d want 0", rc); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency got %0d want 2", lat); end
        checks++; if (dd !== 1 || ewd !== 1 || fd !== 0) begin errors++; $display("FAIL illegal_pulses got dd%0d ewd%0d fd%0d want 1 1 0", dd, ewd, fd); end
        checks++; if (data_reg !== exp_data) begin errors++; $display("FAIL illegal_data_reg got %h want %h", data_reg, exp_data); end
    endtask

    task automatic test_reset_mid;
        op_code = 4'b1101; SR1 = 32'h400; pc = 8'h44; data_req = 1; fetch_req = 1;
        repeat (5) @(negedge Clk);
        checks++; if (mem_req !== 1'b1 || add_bus !== 32'h400) begin errors++; $display("FAIL mid_active got %b/%h want 1/400", mem_req, add_bus); end
        Reset = 1; data_req = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || add_bus !== 32'h0 || RW !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got %b/%h/%b want 0/0/0", mem_req, add_bus, RW); end
        @(negedge Clk);
        Reset = 0;
        xact(0, 32'hCAFEF00D);
        checks++; if (a0 !== 32'h44 || r0 !== 1'b1) begin errors++; $display("FAIL mid_fetch_bus got %h/%b want 44/1", a0, r0); end
        checks++; if (instr !== 32'hCAFEF00D || fd !== 1 || dd !== 0) begin errors++; $display("FAIL mid_fetch got %h fd%0d dd%0d want cafef00d 1 0", instr, fd, dd); end
        checks++; if (data_reg !== 32'h0 || lat !== 4) begin errors++; $display("FAIL mid_after got %h lat%0d want 0 4", data_reg, lat); end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_ldr;
        test_store;
        test_data_run;
        test_timeout;
        test_illegal;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
